// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone copy master: FSM state encoding,
// byte-select constant and small state-classification helpers.
package wb_master_pkg;

  localparam int unsigned WB_DAT_W   = 32;
  localparam logic [3:0]  WB_SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FINISH  = 3'd5
  } wb_state_e;

  // States in which the initiator waits for ack/err from the target.
  function automatic logic is_wait(input wb_state_e s);
    return (s == ST_RD_WAIT) || (s == ST_WR_WAIT);
  endfunction

  // States in which a bus cycle is open (cyc asserted).
  function automatic logic is_bus(input wb_state_e s);
    return (s == ST_RD_REQ) || (s == ST_RD_WAIT) ||
           (s == ST_WR_REQ) || (s == ST_WR_WAIT);
  endfunction

  // States belonging to the read half of a word transfer.
  function automatic logic is_rd(input wb_state_e s);
    return (s == ST_RD_REQ) || (s == ST_RD_WAIT);
  endfunction

  // States belonging to the write half of a word transfer.
  function automatic logic is_wr(input wb_state_e s);
    return (s == ST_WR_REQ) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Per-access wait watchdog. Down-counter reloaded while clear_i is high and
// decremented on every enabled cycle; expired_o flags the TIMEOUT-th
// consecutive enabled cycle (terminal count reached while still enabled).
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // TIMEOUT-1 is the largest value ever loaded, so clog2(TIMEOUT) bits suffice.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on clear, otherwise count down toward zero while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD_VAL;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone pipelined initiator that copies len_i 32-bit words from src to
// dst, one read followed by one write per word, holding cyc for the whole
// transfer.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start_i; bus released
// RD_REQ     | read request on bus (stb=1, we=0, adr=src), held while stalled
// RD_WAIT    | read issued, waiting for ack/err or watchdog expiry
// WR_REQ     | write request on bus (stb=1, we=1, adr=dst), held while stalled
// WR_WAIT    | write issued, waiting for ack/err or watchdog expiry
// FINISH     | bus released; done pulse follows on the next cycle
module wb_copy_master
  import wb_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   src_adr_i,
  input  logic [ADDR_W-1:0]   dst_adr_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic [3:0]          wb_sel_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_stall_i
);

  localparam logic [ADDR_W-1:0] WORD_STRIDE = ADDR_W'(4);
  localparam logic [LEN_W-1:0]  LAST_WORD   = LEN_W'(1);

  wb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [WB_DAT_W-1:0] data_q, data_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                tmo_clear;
  logic                tmo_enable;
  logic                tmo_expired;

  // The watchdog runs only across consecutive wait cycles of one access;
  // every wait is preceded by a request state, which reloads it.
  assign tmo_enable = is_wait(state_q);
  assign tmo_clear  = !is_wait(state_q);

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  // Next-state and datapath updates for the copy sequence.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    err_d   = err_q;
    // done is registered from FINISH so it pulses the cycle after it.
    done_d  = (state_q == ST_FINISH);

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d   = {src_adr_i[ADDR_W-1:2], 2'b00};
          dst_d   = {dst_adr_i[ADDR_W-1:2], 2'b00};
          len_d   = len_i;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? ST_FINISH : ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        if (!wb_stall_i) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // err wins over a simultaneous ack; ack wins over watchdog expiry.
        if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (wb_ack_i) begin
          data_d  = wb_dat_i;
          state_d = ST_WR_REQ;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_WR_REQ: begin
        if (!wb_stall_i) begin
          state_d = ST_WR_WAIT;
        end
      end

      ST_WR_WAIT: begin
        if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (wb_ack_i) begin
          src_d   = src_q + WORD_STRIDE;
          dst_d   = dst_q + WORD_STRIDE;
          len_d   = len_q - 1'b1;
          state_d = (len_q == LAST_WORD) ? ST_FINISH : ST_RD_REQ;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Bus outputs decoded from the registered state; all are zero in IDLE
  // and FINISH, so an abort by reset releases the bus on the next cycle.
  always_comb begin
    wb_cyc_o = is_bus(state_q);
    wb_stb_o = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    wb_we_o  = is_wr(state_q);
    wb_sel_o = is_bus(state_q) ? WB_SEL_ALL : 4'h0;
    wb_adr_o = '0;
    if (is_rd(state_q)) begin
      wb_adr_o = src_q;
    end else if (is_wr(state_q)) begin
      wb_adr_o = dst_q;
    end
  end

  assign wb_dat_o = data_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule
